// File: rtl/cnn_udiv_20ns_9ns_seq.sv
// rtl/cnn_udiv_20ns_9ns_seq.sv - sequential 20b/9b unsigned restoring divider with ap_start/ap_done handshake
module cnn_udiv_20ns_9ns_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 20,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 11
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_ready,
  output logic        ap_idle,
  output logic        ap_done,
  input  logic [19:0] din0,
  input  logic [8:0]  din1,
  output logic [10:0] quot,
  output logic [8:0]  rem,
  output logic        div_by_zero,
  output logic        overflow
);

  // Only the 20/9/11 shape is implemented; the parameters exist for drop-in
  // compatibility with the generated cores and have no effect on the logic.
  if (ID < 0 || din0_WIDTH != 20 || din1_WIDTH != 9 || dout_WIDTH != 11) begin : g_unsupported_config
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [19:0] d;        // latched dividend
  logic [8:0]  v;        // latched divisor
  logic [9:0]  r;        // partial remainder
  logic [10:0] qw;       // quotient bits produced so far, MSB first
  logic [3:0]  cnt;      // dividend bit consumed by the current step

  logic        accept;
  logic        in_zero;
  logic        in_ovf;
  logic [9:0]  t;
  logic        ge;
  logic [9:0]  r_next;

  // Accept-edge classification: the top 9 dividend bits bound the quotient,
  // so comparing them with the divisor detects a quotient of 2048 or more.
  always_comb begin
    accept  = ap_start && (state == IDLE);
    in_zero = (din1 == 9'd0);
    in_ovf  = (din0[19:11] >= din1);
  end

  // One restoring-division step on the current dividend bit.
  always_comb begin
    t      = {r[8:0], d[cnt]};
    ge     = (t >= {1'b0, v});
    r_next = ge ? (t - {1'b0, v}) : t;
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; error cases skip CALC and go straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ap_start) state_next = (in_zero || in_ovf) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == 4'd0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ap_idle  = (state == IDLE);
    ap_ready = accept;
  end

  // ap_done is a flop so it is glitch-free and lines up with the result registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) ap_done <= 1'b0;
    else        ap_done <= (state_next == DONE);
  end

  // Datapath: operands are captured on accept; visible results change only when entering DONE.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      d           <= '0;
      v           <= '0;
      r           <= '0;
      qw          <= '0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            d  <= din0;
            v  <= din1;
            qw <= '0;
            if (in_zero) begin
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quot        <= 11'h7FF;
              rem         <= '0;
            end else if (in_ovf) begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quot        <= 11'h7FF;
              rem         <= '0;
            end else begin
              r   <= {1'b0, din0[19:11]};
              cnt <= 4'd10;
            end
          end
        end
        CALC: begin
          r  <= r_next;
          qw <= {qw[9:0], ge};
          if (cnt == 4'd0) begin
            quot        <= {qw[9:0], ge};
            rem         <= r_next[8:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_udiv_20ns_9ns_seq.sv
// tb/tb_cnn_udiv_20ns_9ns_seq.sv - scoreboard testbench for cnn_udiv_20ns_9ns_seq
module tb_cnn_udiv_20ns_9ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [19:0] din0;
  logic [8:0]  din1;
  logic [10:0] quot;
  logic [8:0]  rem;
  logic        div_by_zero;
  logic        overflow;

  cnn_udiv_20ns_9ns_seq #(
    .ID(1), .din0_WIDTH(20), .din1_WIDTH(9), .dout_WIDTH(11)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
    .din0(din0), .din1(din1), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [10:0] q;
    logic [8:0]  r;
    logic        dz;
    logic        ov;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge ap_clk) cyc++;

  // Monitor: push the model result on every accept, pop and compare on every ap_done.
  always @(negedge ap_clk) begin
    exp_t e;
    int unsigned a, b;
    if (!ap_rst) begin
      if (ap_ready && ap_done) check("ready_done_overlap", 1, 0);
      if (ap_done) begin
        check("done_pulse", prev_done, 0);
        if (sb.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("quot", quot, e.q);
          check("rem", rem, e.r);
          check("div_by_zero", div_by_zero, e.dz);
          check("overflow", overflow, e.ov);
          check("latency", cyc - e.acc, e.lat);
        end
      end
      if (ap_ready) begin
        a = din0;
        b = din1;
        e.acc = cyc;
        e.dz = 1'b0; e.ov = 1'b0; e.q = 11'h7FF; e.r = '0; e.lat = 1;
        if (b == 0) e.dz = 1'b1;
        else if (a / b >= 2048) e.ov = 1'b1;
        else begin
          e.q = 11'(a / b);
          e.r = 9'(a % b);
          e.lat = 12;
        end
        sb.push_back(e);
      end
      prev_done = ap_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge ap_clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic run(input logic [19:0] a, input logic [8:0] b);
    @(posedge ap_clk); #1;
    din0 = a; din1 = b; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_drain();
  endtask

  // Hold ap_start through two accepts, changing operands right after the first.
  task automatic back_to_back(input logic [19:0] a0, input logic [8:0] b0,
                              input logic [19:0] a1, input logic [8:0] b1,
                              input int spacing, input string tag);
    int n;
    @(posedge ap_clk); #1;
    din0 = a0; din1 = b0; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    din0 = a1; din1 = b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!ap_ready && n < 40);
    check(tag, n, spacing);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int ra, rb, rr;
    ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    ap_start = 1'b1; #1;
    check("rst_ready_follows", ap_ready, 1);
    ap_start = 1'b0; #1;
    check("rst_ready_low", ap_ready, 0);
    ap_rst = 1'b0;

    run(20'd12345, 9'd97);
    run(20'd1046527, 9'd511);
    run(20'd1048575, 9'd1);
    run(20'd5, 9'd0);
    run(20'd100, 9'd7);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom_range(0, 2047);
      rb = $urandom_range(1, 511);
      rr = $urandom_range(0, rb - 1);
      run(20'(ra * rb + rr), 9'(rb));
    end

    // Reset in the middle of CALC: no ap_done, outputs return to reset values.
    @(posedge ap_clk); #1;
    din0 = 20'd12345; din1 = 9'd97; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    sb.delete();
    #1;
    check("abort_idle", ap_idle, 1);
    check("abort_done", ap_done, 0);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_flags", {div_by_zero, overflow}, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    run(20'd100, 9'd7);

    back_to_back(20'd1000, 9'd10, 20'd5000, 9'd7, 13, "b2b_normal_spacing");
    back_to_back(20'd5, 9'd0, 20'd100, 9'd7, 2, "b2b_error_spacing");

    repeat (3) @(posedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
